// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and encoded index.
// Define ARB_TIMEOUT_EN to enable the MAX_HOLD grant timeout (adds MAX_HOLD/CNT_W parameters and preempt pulse).
module rr_arbiter_8
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] win;
    logic [2:0] idx;
    logic       found;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
`endif

    // First requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            ptr       <= 3'd0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            preempt   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    preempt <= 1'b0;
`endif
                    if (found) begin
                        gnt       <= 8'b1 << win;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
                        ptr       <= win + 3'd1;
                        state     <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    // A normal release wins over a timeout on the same edge.
                    if (!req[gnt_idx]) begin
                        gnt       <= 8'd0;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        gnt       <= 8'd0;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        preempt   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        hold_cnt  <= hold_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: vector table, corner-case sequences and a
// randomized run against a cycle-level reference model (honours ARB_TIMEOUT_EN).
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the resource, whose turn is first, how long held.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_preempt;

    typedef struct {
        logic [7:0] req;
        logic [7:0] exp_gnt;
        logic [2:0] exp_idx;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        m_owner   = -1;
        m_ptr     = 0;
        m_held    = 0;
        m_preempt = 0;
    endtask

    task automatic modelStep(input logic [7:0] r);
        if (m_owner < 0) begin
            m_preempt = 0;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (r[c]) begin
                    m_owner = c;
                    m_ptr   = (c + 1) % 8;
                    m_held  = 1;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner   = -1;
            m_preempt = 0;
`ifdef ARB_TIMEOUT_EN
        end else if (m_held == MAX_HOLD) begin
            m_owner   = -1;
            m_preempt = 1;
`endif
        end else begin
            m_held = m_held + 1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r);
        req = r;
        @(posedge clk);
        modelStep(r);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eg, input logic [2:0] ei,
                               input logic ev, input logic ep);
        checks++;
        if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || preempt !== ep) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%h idx=%0d valid=%b preempt=%b, expected gnt=%h idx=%0d valid=%b preempt=%b",
                     name, gnt, gnt_idx, gnt_valid, preempt, eg, ei, ev, ep);
        end
    endtask

    task automatic checkModel(input string name);
        logic [7:0] eg;
        logic [2:0] ei;
        eg = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
        ei = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        checkOutput(name, eg, ei, m_owner >= 0, m_preempt);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req   = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        logic [7:0] r;
        int o;

        modelReset();

        // Reset held with every requester active.
        rst_n = 1'b0;
        req   = 8'hFF;
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(8'hFF);
        checkOutput("reset_first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

        // Vector table, starting from idle with ptr=0.
        vecs.push_back('{8'h10, 8'h10, 3'd4, 1'b1});
        vecs.push_back('{8'h10, 8'h10, 3'd4, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{8'h41, 8'h40, 3'd6, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{8'h81, 8'h80, 3'd7, 1'b1});
        vecs.push_back('{8'h01, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 3'd0, 1'b1});
        vecs.push_back('{8'h03, 8'h01, 3'd0, 1'b1});
        vecs.push_back('{8'h02, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{8'h03, 8'h02, 3'd1, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{8'h01, 8'h01, 3'd0, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 3'd0, 1'b0});
        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_idx, vecs[i].exp_valid, 1'b0);
        end

        // Rotation with all requesters active: 0..7 then back to 0.
        doReset();
        for (int k = 0; k < 9; k++) begin
            o = k % 8;
            applyStimulus(8'hFF);
            checkOutput($sformatf("rot_grant%0d", k), 8'd1 << o, 3'(o), 1'b1, 1'b0);
            applyStimulus(8'hFF);
            checkOutput($sformatf("rot_hold%0d", k), 8'd1 << o, 3'(o), 1'b1, 1'b0);
            applyStimulus(8'hFF & ~(8'd1 << o));
            checkOutput($sformatf("rot_gap%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a grant.
        doReset();
        applyStimulus(8'h04);
        checkOutput("async_pre", 8'h04, 3'd2, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_mid", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        applyStimulus(8'hFF);
        checkOutput("async_ptr_zero", 8'h01, 3'd0, 1'b1, 1'b0);

        // Long hold by requester 0 with requester 1 waiting.
        doReset();
        applyStimulus(8'h03);
        checkOutput("hold_start", 8'h01, 3'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 2; i <= MAX_HOLD; i++) begin
            applyStimulus(8'h03);
            checkOutput($sformatf("hold_cycle%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        applyStimulus(8'h03);
        checkOutput("timeout_preempt", 8'h00, 3'd0, 1'b0, 1'b1);
        applyStimulus(8'h03);
        checkOutput("timeout_next", 8'h02, 3'd1, 1'b1, 1'b0);
`else
        for (int i = 2; i <= 40; i++) begin
            applyStimulus(8'h03);
            checkOutput($sformatf("hold_cycle%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
        end
`endif

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 9) == 0) r = 8'h00;
            if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 99) < 94);
            applyStimulus(r);
            checkModel($sformatf("random%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
